manchester_codec: RTL and testbench
===================================

// Module: manchester_codec
// PURPOSE
//  Parametrised Manchester transmitter + receiver pair; successor to the fixed 8-bit encoder.
//  TX serialises DATA_W-bit words (valid/ready) into framed Manchester code with a
//  programmable bit period. RX decodes a line back into words, resyncs on mid-bit edges
//  and flags code violations. Sits between the pin mux (uo_out/ui_in) and user logic.
// PARAMETERS
//  DATA_W        8   payload bits per frame, 1..32, sent MSB first
//  HALF_BIT_CYC  4   clk cycles per half-bit, >=2, even
//  POLARITY      0   0: IEEE 802.3 ('1' = low->high), 1: G.E. Thomas ('1' = high->low)
// PORTS
//  clk       in   1       clock, all logic rising-edge
//  rst       in   1       reset, synchronous, active-high
//  s_valid   in   1       TX word valid
//  s_ready   out  1       TX can accept word
//  s_data    in   DATA_W  TX word
//  tx_line   out  1       Manchester line output (registered)
//  tx_busy   out  1       TX frame in progress
//  rx_line   in   1       Manchester line input (asynchronous)
//  m_valid   out  1       1-cycle pulse: RX word complete
//  m_data    out  DATA_W  RX word, held until next m_valid
//  rx_err    out  1       1-cycle pulse: code violation, frame dropped
// BEHAVIOUR
//  Idle level IDLE_LVL = ~POLARITY (line idles at level opposite the start bit's 1st half).
//  Reset: tx_line=IDLE_LVL, s_ready=0, tx_busy=0, m_valid=0, m_data=0, rx_err=0; both FSMs IDLE.
//  Reset mid-frame aborts immediately: tx_line returns to IDLE_LVL on the cycle after rst.
//  Frame = 1 start bit (value 1) + DATA_W data bits; each bit = 2 halves x HALF_BIT_CYC cycles.
//  TX FSM IDLE -> START -> DATA -> IDLE.
//   - IDLE: s_ready=1, tx_busy=0. Accept on s_valid&&s_ready; word latched, s_ready drops.
//   - tx_line shows start bit 1st half from the cycle after acceptance; tx_busy=1 same cycle.
//   - DATA shifts MSB first; bit counter DATA_W-1..0; half-bit counter 0..HALF_BIT_CYC-1.
//   - After last half of bit 0: IDLE, tx_line=IDLE_LVL; >=1 idle cycle between frames.
//   - Frame length on line = 2*(DATA_W+1)*HALF_BIT_CYC cycles exactly.
//   - s_data/s_valid changes while busy are ignored.
//  RX input: 2-flop synchroniser, then edge detector (3 cycles input-to-edge latency).
//  RX FSM IDLE -> DATA -> (IDLE | HOLDOFF).
//   - IDLE: edge away from IDLE_LVL marks start of start-bit 1st half; phase counter cleared.
//   - Sample each half at offset HALF_BIT_CYC/2 within it; bit = value of 2nd-half sample
//     (POLARITY=0) or its inverse (POLARITY=1). Start bit is checked, not stored.
//   - Resync: a transition seen between 1st- and 2nd-half sample points is the mid-bit edge;
//     phase counter reloads so next 2nd-half sample is HALF_BIT_CYC/2 after that edge.
//     Tolerates +/-(HALF_BIT_CYC/2 - 1) cycles of edge jitter per bit.
//   - Both half samples equal (incl. bad start bit) -> rx_err pulse, no m_valid,
//     go HOLDOFF: wait until line = IDLE_LVL for 2*HALF_BIT_CYC consecutive cycles -> IDLE.
//   - After last bit's 2nd-half sample: next cycle m_data updated, m_valid=1 for 1 cycle,
//     FSM -> IDLE. No backpressure; consumer must take m_data on the pulse.
//  TX and RX are independent; simultaneous TX/RX allowed; rx_err and m_valid never same cycle.
// TESTING
//  T1 POLARITY=0,DATA_W=8,HALF=4: send 8'hA5 -> start 0000_1111 then per bit 1=L4H4, 0=H4L4;
//     72 cycles busy; s_ready low throughout.
//  T2 loopback tx_line->rx_line, frames 8'hA5, 8'h00, 8'hFF back-to-back -> three m_valid
//     pulses with same data in order, rx_err never set.
//  T3 POLARITY=1 loopback, DATA_W=16, 16'h1234 -> start bit H4L4, m_data=16'h1234.
//  T4 drive rx_line flat for a full bit after start (violation at bit 3) -> one rx_err pulse,
//     no m_valid; next clean frame 8'h3C decodes correctly after holdoff.
//  T5 HALF=8, RX edges jittered +/-3 cycles randomly, 100 random words -> all decoded, 0 errors.
//  T6 assert rst mid-frame (bit 4) -> next cycle tx_line=IDLE_LVL, tx_busy=0, s_ready=0,
//     then s_ready=1 one cycle after rst falls; RX emits nothing for the aborted frame.

Source files
------------

// File: rtl/manchester_codec.sv
// Manchester transmitter and receiver pair sharing one clock.
// TX frames each word as a start bit plus DATA_W data bits, MSB first.
// RX resynchronises on mid-bit edges and drops frames that contain a code violation.
module manchester_codec #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned HALF_BIT_CYC = 4,
  parameter bit          POLARITY     = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              tx_line,
  output logic              tx_busy,
  input  logic              rx_line,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              rx_err
);

  localparam logic        IDLE_LVL = ~POLARITY;
  localparam int unsigned BW       = $clog2(DATA_W + 1);
  localparam int unsigned HW       = $clog2(HALF_BIT_CYC);
  localparam int unsigned PW       = $clog2(2 * HALF_BIT_CYC);

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYC - 1);
  localparam logic [PW-1:0] SAMP0     = PW'(HALF_BIT_CYC / 2);
  localparam logic [PW-1:0] SAMP1     = PW'(HALF_BIT_CYC + HALF_BIT_CYC / 2);
  // Phase one cycle past the mid-bit edge, so the next 2nd-half sample lands HALF/2 after it
  localparam logic [PW-1:0] RELOAD    = PW'(HALF_BIT_CYC + 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(2 * HALF_BIT_CYC - 1);

  typedef enum logic [1:0] {TxIdle, TxStart, TxData} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxData, RxHoldoff} rx_state_e;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e         tx_state_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] tx_shift_nxt;
  logic [BW-1:0]     tx_bit_q;
  logic [HW-1:0]     tx_cyc_q;
  logic              tx_half_q;

  assign tx_shift_nxt = tx_shift_q << 1;

  // TX FSM: accept a word, then walk start bit and data bits half by half
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_cyc_q   <= '0;
      tx_half_q  <= 1'b0;
      tx_line    <= IDLE_LVL;
      tx_busy    <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      unique case (tx_state_q)
        TxIdle: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            s_ready    <= 1'b0;
            tx_busy    <= 1'b1;
            tx_shift_q <= s_data;
            tx_cyc_q   <= '0;
            tx_half_q  <= 1'b0;
            tx_state_q <= TxStart;
            tx_line    <= POLARITY;  // 1st half of the start bit ('1')
          end
        end
        TxStart, TxData: begin
          tx_cyc_q <= tx_cyc_q + 1'b1;
          if (tx_cyc_q == HALF_LAST) begin
            tx_cyc_q  <= '0;
            tx_half_q <= ~tx_half_q;
            if (!tx_half_q) begin
              tx_line <= (tx_state_q == TxStart) ? ~POLARITY : tx_shift_q[DATA_W-1] ^ POLARITY;
            end else if (tx_state_q == TxStart) begin
              tx_state_q <= TxData;
              tx_bit_q   <= BW'(DATA_W - 1);
              tx_line    <= ~tx_shift_q[DATA_W-1] ^ POLARITY;
            end else if (tx_bit_q == '0) begin
              tx_state_q <= TxIdle;
              tx_busy    <= 1'b0;
              tx_line    <= IDLE_LVL;
            end else begin
              tx_shift_q <= tx_shift_nxt;
              tx_bit_q   <= tx_bit_q - 1'b1;
              tx_line    <= ~tx_shift_nxt[DATA_W-1] ^ POLARITY;
            end
          end
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic              rx_s1_q, rx_s2_q, rx_s3_q;
  logic              rx_lvl, rx_edge, rx_bitval;
  rx_state_e         rx_state_q;
  logic [PW-1:0]     rx_ph_q;
  logic [PW-1:0]     rx_hold_q;
  logic [BW-1:0]     rx_bit_q;
  logic              rx_first_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W-1:0] rx_shift_nxt;

  assign rx_lvl       = rx_s2_q;
  assign rx_edge      = rx_s2_q ^ rx_s3_q;
  assign rx_bitval    = rx_lvl ^ POLARITY;
  assign rx_shift_nxt = DATA_W'({rx_shift_q, rx_bitval});

  // RX synchroniser and FSM: hunt start edge, sample halves, resync on mid-bit edges
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= IDLE_LVL;
      rx_s2_q    <= IDLE_LVL;
      rx_s3_q    <= IDLE_LVL;
      rx_state_q <= RxIdle;
      rx_ph_q    <= '0;
      rx_hold_q  <= '0;
      rx_bit_q   <= '0;
      rx_first_q <= 1'b0;
      rx_shift_q <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      rx_err     <= 1'b0;
    end else begin
      rx_s1_q <= rx_line;
      rx_s2_q <= rx_s1_q;
      rx_s3_q <= rx_s2_q;
      m_valid <= 1'b0;
      rx_err  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_edge && (rx_lvl != IDLE_LVL)) begin
            rx_state_q <= RxData;
            rx_ph_q    <= PW'(1);
            rx_bit_q   <= BW'(DATA_W);  // DATA_W indexes the start bit
          end
        end
        RxData: begin
          rx_ph_q <= (rx_ph_q == PH_LAST) ? '0 : rx_ph_q + 1'b1;
          if (rx_ph_q == SAMP0) begin
            rx_first_q <= rx_lvl;
          end else if (rx_edge && (rx_ph_q > SAMP0) && (rx_ph_q < SAMP1)) begin
            rx_ph_q <= RELOAD;
          end else if (rx_ph_q == SAMP1) begin
            if ((rx_lvl == rx_first_q) || ((rx_bit_q == BW'(DATA_W)) && !rx_bitval)) begin
              rx_err     <= 1'b1;
              rx_hold_q  <= '0;
              rx_state_q <= RxHoldoff;
            end else if (rx_bit_q == BW'(DATA_W)) begin
              rx_bit_q <= rx_bit_q - 1'b1;
            end else begin
              rx_shift_q <= rx_shift_nxt;
              rx_bit_q   <= rx_bit_q - 1'b1;
              if (rx_bit_q == '0) begin
                m_data     <= rx_shift_nxt;
                m_valid    <= 1'b1;
                rx_state_q <= RxIdle;
              end
            end
          end
        end
        RxHoldoff: begin
          if (rx_lvl != IDLE_LVL) begin
            rx_hold_q <= '0;
          end else if (rx_hold_q == PH_LAST) begin
            rx_state_q <= RxIdle;
          end else begin
            rx_hold_q <= rx_hold_q + 1'b1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_manchester_codec.sv
// Directed and randomised bench for manchester_codec, three parameterisations.
module tb_manchester_codec;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: DATA_W=8, HALF=4, POLARITY=0
  logic       a_s_valid = 1'b0, a_s_ready, a_tx_line, a_tx_busy, a_rx_line, a_m_valid, a_rx_err;
  logic [7:0] a_s_data = 8'h00, a_m_data;
  logic       a_loop = 1'b1, a_rx_drv = 1'b1;
  assign a_rx_line = a_loop ? a_tx_line : a_rx_drv;

  manchester_codec #(.DATA_W(8), .HALF_BIT_CYC(4), .POLARITY(1'b0)) u_a (
    .clk(clk), .rst(rst), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
    .tx_line(a_tx_line), .tx_busy(a_tx_busy), .rx_line(a_rx_line), .m_valid(a_m_valid),
    .m_data(a_m_data), .rx_err(a_rx_err)
  );

  // Instance B: DATA_W=16, HALF=4, POLARITY=1, always looped back
  logic        b_s_valid = 1'b0, b_s_ready, b_tx_line, b_tx_busy, b_m_valid, b_rx_err;
  logic [15:0] b_s_data = 16'h0000, b_m_data;

  manchester_codec #(.DATA_W(16), .HALF_BIT_CYC(4), .POLARITY(1'b1)) u_b (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .tx_line(b_tx_line), .tx_busy(b_tx_busy), .rx_line(b_tx_line), .m_valid(b_m_valid),
    .m_data(b_m_data), .rx_err(b_rx_err)
  );

  // Instance C: DATA_W=8, HALF=8, POLARITY=0, RX driven with jittered frames
  logic       c_s_valid = 1'b0, c_s_ready, c_tx_line, c_tx_busy, c_m_valid, c_rx_err;
  logic [7:0] c_s_data = 8'h00, c_m_data;
  logic       c_rx_drv = 1'b1;

  manchester_codec #(.DATA_W(8), .HALF_BIT_CYC(8), .POLARITY(1'b0)) u_c (
    .clk(clk), .rst(rst), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
    .tx_line(c_tx_line), .tx_busy(c_tx_busy), .rx_line(c_rx_drv), .m_valid(c_m_valid),
    .m_data(c_m_data), .rx_err(c_rx_err)
  );

  logic [7:0]  a_rxq[$], a_expq[$], c_rxq[$], c_expq[$];
  logic [15:0] b_rxq[$];
  int a_errs = 0, b_errs = 0, c_errs = 0, both = 0;

  // Collect RX words and error pulses away from the active edge
  always @(negedge clk) begin
    if (a_m_valid) a_rxq.push_back(a_m_data);
    if (b_m_valid) b_rxq.push_back(b_m_data);
    if (c_m_valid) c_rxq.push_back(c_m_data);
    if (a_rx_err) a_errs++;
    if (b_rx_err) b_errs++;
    if (c_rx_err) c_errs++;
    if ((a_m_valid && a_rx_err) || (b_m_valid && b_rx_err) || (c_m_valid && c_rx_err)) both++;
  end

  // Line level of frame cycle 'cyc': start bit '1' then data MSB first.
  // Polarity 0 sends '1' as low then high; polarity 1 as high then low.
  function automatic logic exp_level(input logic [31:0] word, input int dw, input int half,
                                     input bit pol, input int cyc);
    int   b_idx  = cyc / (2 * half);
    logic second = ((cyc / half) % 2) == 1;
    logic b      = (b_idx == 0) ? 1'b1 : word[dw-b_idx];
    return (second ? b : ~b) ^ pol;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at the first negedge after acceptance
  task automatic send_a(input logic [7:0] w);
    int n = 0;
    while (!a_s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("a_ready_wait", {31'd0, a_s_ready}, 32'd1);
    a_s_valid = 1'b1;
    a_s_data  = w;
    @(negedge clk);
    a_s_valid = 1'b0;
    if (a_loop) a_expq.push_back(w);
  endtask

  // Drive one frame into instance C with bit-boundary edges moved by up to +/-3 cycles
  task automatic drive_c_frame(input logic [7:0] w);
    logic lv[144];
    int   t, j;
    logic lo, ln;
    for (int i = 0; i < 144; i++) lv[i] = exp_level({24'd0, w}, 8, 8, 1'b0, i);
    for (int k = 1; k < 9; k++) begin
      t  = k * 16;
      lo = lv[t-1];
      ln = lv[t];
      if (lo != ln) begin
        j = int'($urandom_range(6)) - 3;
        if (j < 0) for (int i = t + j; i < t; i++) lv[i] = ln;
        else       for (int i = t; i < t + j; i++) lv[i] = lo;
      end
    end
    for (int i = 0; i < 144; i++) begin
      c_rx_drv = lv[i];
      @(negedge clk);
    end
    c_rx_drv = 1'b1;
    repeat (2 + $urandom_range(4)) @(negedge clk);
    c_expq.push_back(w);
  endtask

  initial begin
    int n, e0, r0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_line",  {31'd0, a_tx_line}, 32'd1);
    check("rst_b_line",  {31'd0, b_tx_line}, 32'd0);
    check("rst_ready",   {31'd0, a_s_ready}, 32'd0);
    check("rst_busy",    {31'd0, a_tx_busy}, 32'd0);
    check("rst_m_valid", {31'd0, a_m_valid}, 32'd0);
    check("rst_m_data",  {24'd0, a_m_data},  32'd0);
    check("rst_rx_err",  {31'd0, a_rx_err},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_rise", {31'd0, a_s_ready}, 32'd1);

    // T1: exact waveform of 8'hA5, inputs wiggled while busy
    send_a(8'hA5);
    for (int k = 0; k < 72; k++) begin
      if (k == 10) begin a_s_valid = 1'b1; a_s_data = 8'h3C; end
      if (k == 20) a_s_valid = 1'b0;
      check("t1_line",  {31'd0, a_tx_line}, {31'd0, exp_level(32'hA5, 8, 4, 1'b0, k)});
      check("t1_busy",  {31'd0, a_tx_busy}, 32'd1);
      check("t1_ready", {31'd0, a_s_ready}, 32'd0);
      @(negedge clk);
    end
    check("t1_end_line",  {31'd0, a_tx_line}, 32'd1);
    check("t1_end_busy",  {31'd0, a_tx_busy}, 32'd0);
    check("t1_end_ready", {31'd0, a_s_ready}, 32'd0);
    @(negedge clk);
    check("t1_ready_back", {31'd0, a_s_ready}, 32'd1);

    // T2: back-to-back loopback
    send_a(8'hA5);
    send_a(8'h00);
    send_a(8'hFF);
    n = 0;
    while (a_rxq.size() < a_expq.size() && n < 1000) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    check("t2_count", a_rxq.size(), a_expq.size());
    for (int i = 0; i < a_expq.size(); i++) check("t2_word", {24'd0, a_rxq[i]}, {24'd0, a_expq[i]});
    check("t2_errs", a_errs, 0);

    // T3: polarity 1, 16-bit loopback
    n = 0;
    while (!b_s_ready && n < 100) begin @(negedge clk); n++; end
    b_s_valid = 1'b1;
    b_s_data  = 16'h1234;
    @(negedge clk);
    b_s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("t3_start", {31'd0, b_tx_line}, {31'd0, exp_level(32'h1234, 16, 4, 1'b1, k)});
      @(negedge clk);
    end
    n = 0;
    while (b_rxq.size() < 1 && n < 400) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("t3_count", b_rxq.size(), 1);
    check("t3_word",  {16'd0, b_rxq[0]}, 32'h1234);
    check("t3_errs",  b_errs, 0);
    check("t3_busy",  {31'd0, b_tx_busy}, 32'd0);

    // T4: flat bit 3 -> one error, then a clean 8'h3C after holdoff
    a_rx_drv = 1'b1;
    a_loop   = 1'b0;
    repeat (4) @(negedge clk);
    e0 = a_errs;
    r0 = a_rxq.size();
    for (int k = 0; k < 32; k++) begin
      a_rx_drv = exp_level(32'hA5, 8, 4, 1'b0, k);
      @(negedge clk);
    end
    a_rx_drv = 1'b0;
    repeat (8) @(negedge clk);
    a_rx_drv = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_err_once", a_errs, e0 + 1);
    check("t4_no_word",  a_rxq.size(), r0);
    for (int k = 0; k < 72; k++) begin
      a_rx_drv = exp_level(32'h3C, 8, 4, 1'b0, k);
      @(negedge clk);
    end
    a_rx_drv = 1'b1;
    repeat (10) @(negedge clk);
    check("t4_count", a_rxq.size(), r0 + 1);
    check("t4_word",  {24'd0, a_rxq[a_rxq.size()-1]}, 32'h3C);
    check("t4_errs",  a_errs, e0 + 1);

    // T5: 100 random words with jittered bit boundaries
    for (int i = 0; i < 100; i++) drive_c_frame(8'($urandom));
    n = 0;
    while (c_rxq.size() < 100 && n < 2000) begin @(negedge clk); n++; end
    check("t5_count", c_rxq.size(), 100);
    for (int i = 0; i < 100; i++) check("t5_word", {24'd0, c_rxq[i]}, {24'd0, c_expq[i]});
    check("t5_errs", c_errs, 0);
    check("t5_c_tx_idle", {30'd0, c_tx_line, c_tx_busy}, 32'd2);

    // T6: reset in the middle of data bit 4
    a_loop = 1'b1;
    repeat (4) @(negedge clk);
    e0 = a_errs;
    r0 = a_rxq.size();
    send_a(8'h96);
    repeat (42) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_line",  {31'd0, a_tx_line}, 32'd1);
    check("t6_busy",  {31'd0, a_tx_busy}, 32'd0);
    check("t6_ready", {31'd0, a_s_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6_ready_back", {31'd0, a_s_ready}, 32'd1);
    repeat (60) @(negedge clk);
    check("t6_no_word", a_rxq.size(), r0);
    check("t6_no_err",  a_errs, e0);
    check("both_same_cycle", both, 0);
    check("c_ready_idle", {31'd0, c_s_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
